// File: rtl/instr_encoder.sv
// Field-level MIPS instruction encoder: packs requests into 32-bit words, buffers them
// in a small circular FIFO and emits each with an address bound at pop time.
module instr_encoder #(
    parameter int unsigned    DEPTH     = 4,
    parameter int unsigned    AW        = 32,
    parameter logic [AW-1:0]  BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    kind,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    funct,
    input  logic [15:0]   imm,
    input  logic [25:0]   target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_addr,
    input  logic          load_addr,
    input  logic [AW-1:0] addr_in,
    output logic [15:0]   count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned WW = 32;

    localparam logic [3:0] KIND_RTYPE = 4'd0;
    localparam logic [3:0] KIND_J     = 4'd10;

    logic [5:0]    op;
    logic [WW-1:0] word;
    logic [WW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [AW-1:0] addr_q;
    logic [15:0]   count_q;

    // Opcode lookup by instruction kind
    always_comb begin
        op = 6'b000000;
        case (kind)
            4'd0:  op = 6'b000000;
            4'd1:  op = 6'b110111;
            4'd2:  op = 6'b100011;
            4'd3:  op = 6'b100100;
            4'd4:  op = 6'b100000;
            4'd5:  op = 6'b111111;
            4'd6:  op = 6'b101011;
            4'd7:  op = 6'b101000;
            4'd8:  op = 6'b000100;
            4'd9:  op = 6'b000101;
            4'd10: op = 6'b000010;
            4'd11: op = 6'b001000;
            4'd12: op = 6'b001100;
            4'd13: op = 6'b001101;
            4'd14: op = 6'b001010;
            4'd15: op = 6'b011000;
            default: op = 6'b000000;
        endcase
    end

    // Format selection; fields are packed verbatim
    always_comb begin
        word = {op, rs, rt, imm};
        if (kind == KIND_RTYPE) begin
            word = {6'b000000, rs, rt, rd, shamt, funct};
        end else if (kind == KIND_J) begin
            word = {6'b000010, target};
        end
    end

    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {IW{1'b0}}};
    assign empty = (wr_ptr == rd_ptr);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_instr = mem[rd_ptr[IW-1:0]];
    assign out_addr  = addr_q;
    assign count     = count_q;

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // A reload overrides the post-pop increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
        end else begin
            if (load_addr) begin
                addr_q <= addr_in;
            end else if (pop) begin
                addr_q <= addr_q + AW'(4);
            end
            if (pop) count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        load_addr = 1'b0;
    logic [31:0] addr_in = '0;
    logic [15:0] count;

    instr_encoder #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .load_addr(load_addr), .addr_in(addr_in), .count(count)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_addr = 32'h0;
    logic [15:0] m_count = 16'h0;
    logic [63:0] dut_pops[$];

    int unsigned opc [16] = '{'h00, 'h37, 'h23, 'h24, 'h20, 'h3F, 'h2B, 'h28,
                              'h04, 'h05, 'h02, 'h08, 'h0C, 'h0D, 'h0A, 'h18};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] encode(input int unsigned k, input int unsigned f_rs,
                                           input int unsigned f_rt, input int unsigned f_rd,
                                           input int unsigned f_sh, input int unsigned f_fn,
                                           input int unsigned f_imm, input int unsigned f_tgt);
        int unsigned w;
        if (k == 0)
            w = f_rs * (2**21) + f_rt * (2**16) + f_rd * (2**11) + f_sh * (2**6) + f_fn;
        else if (k == 10)
            w = 2 * (2**26) + f_tgt;
        else
            w = opc[k] * (2**26) + f_rs * (2**21) + f_rt * (2**16) + f_imm;
        return 32'(w);
    endfunction

    task automatic check_state();
        check_eq("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) check_eq("out_instr", 64'(out_instr), 64'(mq[0]));
        check_eq("out_addr", 64'(out_addr), 64'(m_addr));
        check_eq("count", 64'(count), 64'(m_count));
    endtask

    // Entered and left on a falling edge; inputs already driven for this cycle
    task automatic cycle();
        bit do_push, do_pop;
        check_state();
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        if (do_pop) dut_pops.push_back({out_addr, out_instr});
        @(posedge clk);
        if (do_pop) begin
            void'(mq.pop_front());
            m_count = m_count + 16'd1;
        end
        if (load_addr) m_addr = addr_in;
        else if (do_pop) m_addr = m_addr + 32'd4;
        if (do_push) mq.push_back(encode(kind, rs, rt, rd, shamt, funct, imm, target));
        @(negedge clk);
    endtask

    task automatic set_req(input logic [3:0] k, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [4:0] s, input logic [5:0] fn,
                           input logic [15:0] im, input logic [25:0] tg);
        in_valid = 1'b1; kind = k; rs = a; rt = b; rd = c; shamt = s;
        funct = fn; imm = im; target = tg;
    endtask

    task automatic model_reset();
        mq.delete();
        m_addr = 32'h0;
        m_count = 16'h0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_out_addr", 64'(out_addr), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // ADDI push, then pop
        set_req(4'd11, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
        cycle();
        in_valid = 1'b0;
        check_eq("addi_valid", 64'(out_valid), 64'd1);
        check_eq("addi_instr", 64'(out_instr), 64'h2008_0005);
        check_eq("addi_addr", 64'(out_addr), 64'h0);
        out_ready = 1'b1;
        cycle();
        check_eq("addi_count", 64'(count), 64'd1);
        check_eq("addi_next_addr", 64'(out_addr), 64'h4);

        // Streamed mix of formats
        load_addr = 1'b1; addr_in = 32'h0;
        cycle();
        load_addr = 1'b0;
        dut_pops.delete();
        set_req(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0);     cycle();
        set_req(4'd6, 5'd29, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0);  cycle();
        set_req(4'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);    cycle();
        set_req(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010); cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check_eq("mix_npops", 64'(dut_pops.size()), 64'd4);
        if (dut_pops.size() == 4) begin
            check_eq("mix_w0", dut_pops[0], {32'h0, 32'h0109_5020});
            check_eq("mix_w1", dut_pops[1], {32'h4, 32'hAFBF_0004});
            check_eq("mix_w2", dut_pops[2], {32'h8, 32'h1022_FFFF});
            check_eq("mix_w3", dut_pops[3], {32'hC, 32'h0800_0010});
        end

        // Fill to full, hold a fifth request, release one slot
        out_ready = 1'b0;
        dut_pops.delete();
        for (int i = 0; i < 4; i++) begin
            set_req(4'd11, 5'd0, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i), 26'd0);
            cycle();
        end
        check_eq("full_in_ready", 64'(in_ready), 64'd0);
        set_req(4'd13, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0);
        repeat (2) cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check_eq("after_pop_in_ready", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) cycle();
        check_eq("full_npops", 64'(dut_pops.size()), 64'd5);
        if (dut_pops.size() == 5) begin
            for (int i = 0; i < 4; i++)
                check_eq("full_order", 64'(dut_pops[i][31:0]), 64'(32'h2000_0000 | (i << 16) | i));
            check_eq("full_fifth", 64'(dut_pops[4][31:0]), 64'h3464_BEEF);
        end

        // Reload coinciding with a pop
        out_ready = 1'b0;
        load_addr = 1'b1; addr_in = 32'h8;
        cycle();
        load_addr = 1'b0;
        set_req(4'd2, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0); cycle();
        set_req(4'd7, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'h5678, 26'd0); cycle();
        in_valid = 1'b0;
        out_ready = 1'b1; load_addr = 1'b1; addr_in = 32'h0040_0000;
        check_eq("ld_pop_old_addr", 64'(out_addr), 64'h8);
        cycle();
        load_addr = 1'b0;
        check_eq("ld_new_addr", 64'(out_addr), 64'h0040_0000);
        cycle();
        check_eq("ld_inc_addr", 64'(out_addr), 64'h0040_0004);

        // Address wrap
        out_ready = 1'b0;
        load_addr = 1'b1; addr_in = 32'hFFFF_FFFC;
        cycle();
        load_addr = 1'b0;
        set_req(4'd15, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0); cycle();
        set_req(4'd12, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0002, 26'd0); cycle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("wrap_addr0", 64'(out_addr), 64'hFFFF_FFFC);
        cycle();
        check_eq("wrap_addr1", 64'(out_addr), 64'h0);
        cycle();

        // Asynchronous reset with words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(4'd1, 5'(i), 5'd0, 5'd0, 5'd0, 6'd0, 16'hAAAA, 26'd0);
            cycle();
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_count", 64'(count), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        set_req(4'd9, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
        cycle();
        in_valid = 1'b0;
        check_eq("post_rst_valid", 64'(out_valid), 64'd1);
        check_eq("post_rst_instr", 64'(out_instr), 64'h1463_0010);
        check_eq("post_rst_addr", 64'(out_addr), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            load_addr = ($urandom_range(0, 31) == 0);
            addr_in   = $urandom;
            kind   = 4'($urandom);
            rs     = 5'($urandom);
            rt     = 5'($urandom);
            rd     = 5'($urandom);
            shamt  = 5'($urandom);
            funct  = 6'($urandom);
            imm    = 16'($urandom);
            target = 26'($urandom);
            cycle();
        end
        in_valid = 1'b0; load_addr = 1'b0; out_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder for the MIPS multicycle core: the inverse of the main decoder. It accepts field-level instruction requests over a valid/ready handshake and packs each into a 32-bit machine word using the core's opcode set. It buffers the words in a small FIFO and emits them, each tagged with an auto-incrementing byte address, toward instruction-memory loaders and self-test stimulus paths.

## Interface

- DEPTH, 4: FIFO entries; power of two, ≥2.
- AW, 32: address width.
- BASE_ADDR, 0: address counter value after reset.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid & in_ready at clk edge.
- kind  in  4  instruction kind: 0 RTYPE, 1 LD, 2 LW, 3 LBU, 4 LB, 5 SD, 6 SW, 7 SB, 8 BEQ, 9 BNE, 10 J, 11 ADDI, 12 ANDI, 13 ORI, 14 SLTI, 15 DADDI.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- funct  in  6  R-type function field.
- imm  in  16  I-type immediate, raw bits.
- target  in  26  J-type target field.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the word when out_valid & out_ready.
- out_instr  out  32  encoded word at FIFO head.
- out_addr  out  AW  address for the head word.
- load_addr  in  1  synchronous reload of the address counter.
- addr_in  in  AW  value loaded by load_addr.
- count  out  16  number of words popped since reset; wraps.

## Operation

- Opcode map, indexed by kind 0–15: 000000, 110111, 100011, 100100, 100000, 111111, 101011, 101000, 000100, 000101, 000010, 001000, 001100, 001101, 001010, 011000.
- R format (kind 0): {000000, rs, rt, rd, shamt, funct}.
- J format (kind 10): {000010, target}.
- I format (all other kinds): {op, rs, rt, imm}.
- Inputs not used by the selected format are ignored. No sign extension or range checking is done; fields are taken verbatim.
- Encoding is combinational on the inputs. The encoded word is written into the FIFO tail on acceptance.
- FIFO: circular, DEPTH entries, read and write pointers of log2(DEPTH)+1 bits.
  - Full when pointers differ only in the MSB.
  - Empty when pointers are equal.
- in_ready = !full. A push while full does not occur, even if a pop happens in the same cycle.
- out_valid = !empty. out_instr is the head entry.
- out_addr is the address counter value. The address is bound at pop time, not at push time.
- On each pop:
  - the address counter increments by 4, wrapping modulo 2^AW;
  - count increments by 1, wrapping at 2^16.
- load_addr: the counter takes addr_in at the edge.
  - If a pop happens in the same cycle, the popped word still carries the old address, and the counter takes addr_in; load wins over the increment.
- Simultaneous push and pop when neither full nor empty: both take effect; occupancy is unchanged.
- Simultaneous push and pop when empty: only the push takes effect, because out_valid is 0.

## Timing

- Reset (reset = 0, asynchronous):
  - pointers cleared, so in_ready = 1 and out_valid = 0;
  - address counter = BASE_ADDR, count = 0;
  - FIFO storage is not cleared.
  - Deassertion is sampled at the next clk edge.
- Latency: a request accepted at edge N appears at out_valid/out_instr after edge N (one cycle); there is no same-cycle fall-through.
- Throughput: one word per cycle in steady state when out_ready stays high.
- Full FIFO with out_ready high: in_ready rises in the cycle after the pop edge.
- out_instr and out_addr hold stable while out_valid & !out_ready.
- Reset mid-burst discards all buffered words. No partial outputs appear after reset.

## Test plan

- Reset, then push ADDI (kind 11, rs=0, rt=8, imm=0x0005) -> one cycle later out_valid=1, out_instr=0x20080005, out_addr=BASE_ADDR=0; pop -> count=1, out_addr next=4.
- Push RTYPE (rs=8, rt=9, rd=10, shamt=0, funct=0x20), then SW (rs=29, rt=31, imm=0x0004), BEQ (rs=1, rt=2, imm=0xFFFF), J (target=0x0000010), with out_ready=1 -> outputs 0x01095020, 0xAFBF0004, 0x1022FFFF, 0x08000010 at addresses 0, 4, 8, 12.
- Hold out_ready=0 and push DEPTH=4 words -> in_ready=0 after the 4th acceptance; a 5th request is held, not lost. Raise out_ready for one cycle -> in_ready=1 the next cycle and the 5th word is accepted; order is preserved.
- load_addr=1 with addr_in=0x00400000 in the same cycle as a pop at address 8 -> the popped word reports 8, and the next word reports 0x00400000, then 0x00400004.
- Address wrap: load 0xFFFFFFFC, pop two words -> addresses 0xFFFFFFFC, then 0x00000000.
- Assert reset with 3 words buffered -> immediately out_valid=0, in_ready=1, count=0; after release, push one word -> it appears at BASE_ADDR.
